buffered_handshake: RTL and testbench

//  Two-entry buffered (skid) valid/ready handshake stage for HLS middleware streams.

---
 rtl/buffered_handshake.sv | 120 ++++++++++++
 tb/tb_buffered_handshake.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/buffered_handshake.sv
// Two-entry skid buffer for valid/ready streams; every output comes straight from a flop.
// Optional transfer counter on xfer_count enabled by defining BHAND_COUNT_EN.
module buffered_handshake #(
  parameter int DATA_WIDTH  = 8,
  parameter int RESET_TYPE  = 1,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  idata,
  input  logic                   idata_vld,
  output logic                   idata_rdy,
  output logic [DATA_WIDTH-1:0]  odata,
  output logic                   odata_vld,
  input  logic                   odata_rdy
`ifdef BHAND_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] xfer_count
`endif
);

  if (RESET_TYPE != 1) begin : g_bad_reset_type
    $error("buffered_handshake: only RESET_TYPE=1 (async active-low) is supported");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("buffered_handshake: COUNT_WIDTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic                  m_vld_q, m_vld_d;
  logic                  s_vld_q, s_vld_d;
  logic                  rdy_q, rdy_d;
  logic                  accept_s;
  logic                  emit_s;

  assign accept_s = idata_vld & rdy_q;
  assign emit_s   = m_vld_q & odata_rdy;

  // Next-state for the main/skid pair; ready is derived from the next skid state so it stays registered.
  always_comb begin
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    m_vld_d  = m_vld_q;
    s_vld_d  = s_vld_q;
    if (s_vld_q) begin
      if (emit_s) begin
        m_data_d = s_data_q;
        s_vld_d  = 1'b0;
      end else begin
        m_vld_d  = m_vld_q;
      end
    end else if (m_vld_q) begin
      if (accept_s && emit_s) begin
        m_data_d = idata;
      end else if (accept_s) begin
        s_data_d = idata;
        s_vld_d  = 1'b1;
      end else if (emit_s) begin
        m_vld_d  = 1'b0;
      end else begin
        m_vld_d  = m_vld_q;
      end
    end else begin
      if (accept_s) begin
        m_data_d = idata;
        m_vld_d  = 1'b1;
      end else begin
        m_vld_d  = 1'b0;
      end
    end
    rdy_d = ~s_vld_d;
  end

  // Storage flops; reset clears both entries and holds ready low until the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_q <= '0;
      s_data_q <= '0;
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      rdy_q    <= rdy_d;
    end
  end

  assign idata_rdy = rdy_q;
  assign odata     = m_data_q;
  assign odata_vld = m_vld_q;

`ifdef BHAND_COUNT_EN
  logic [COUNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  // Emit counter, wrapping naturally at 2^COUNT_WIDTH.
  always_comb begin
    if (emit_s) begin
      xfer_count_d = xfer_count_q + COUNT_WIDTH'(1);
    end else begin
      xfer_count_d = xfer_count_q;
    end
  end

  // Counter flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_buffered_handshake.sv
// Self-checking bench for buffered_handshake: directed vector table plus hand sequences
// for streaming, random backpressure with a queue scoreboard, mid-stream reset and the counter.
module tb_buffered_handshake;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] idata;
  logic       idata_vld;
  logic       idata_rdy;
  logic [7:0] odata;
  logic       odata_vld;
  logic       odata_rdy;
`ifdef BHAND_COUNT_EN
  logic [3:0] xfer_count;
`endif

  always #5 clk = ~clk;

  buffered_handshake #(
    .DATA_WIDTH (8),
    .RESET_TYPE (1),
    .COUNT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .idata     (idata),
    .idata_vld (idata_vld),
    .idata_rdy (idata_rdy),
    .odata     (odata),
    .odata_vld (odata_vld),
    .odata_rdy (odata_rdy)
`ifdef BHAND_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       ordy;
    logic [7:0] exp_dout;
    logic       exp_ovld;
    logic       exp_irdy;
    logic       chk_dout;
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of random-phase traffic checked against the queue model.
  task automatic model_step(input logic vld, input logic ordy, input logic [7:0] din);
    logic       acc;
    logic       emit;
    logic       hold;
    logic [7:0] held;
    idata_vld = vld;
    odata_rdy = ordy;
    idata     = din;
    acc  = vld && (q.size() < 2);
    emit = (q.size() != 0) && ordy;
    hold = (q.size() != 0) && !ordy;
    held = odata;
    if (emit) void'(q.pop_front());
    if (acc) q.push_back(din);
    tick();
    check("rand_ovld", 32'(odata_vld), 32'(q.size() != 0));
    check("rand_irdy", 32'(idata_rdy), 32'(q.size() < 2));
    if (q.size() != 0) check("rand_order", 32'(odata), 32'(q[0]));
    if (hold) check("rand_stable", 32'(odata), 32'(held));
  endtask

  // n back-to-back beats base+1..base+n with the sink always ready, then one drain cycle.
  task automatic stream(input logic [7:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      idata_vld = 1'b1;
      odata_rdy = 1'b1;
      idata     = base + 8'(i);
      tick();
      check("stream_data", 32'(odata), 32'(base + 8'(i)));
      check("stream_ovld", 32'(odata_vld), 32'd1);
      check("stream_irdy", 32'(idata_rdy), 32'd1);
    end
    idata_vld = 1'b0;
    tick();
    check("stream_drain", 32'(odata_vld), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    idata     = 8'h11;
    idata_vld = 1'b1;
    odata_rdy = 1'b0;

    //          rst   vld   din    ordy  exp_d  ovld  irdy  chk_d
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h22, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'hA2, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 8'hA3, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'hEE, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset, release and the A1/A2/A3 backpressure sequence.
    for (int i = 0; i < 14; i++) begin
      rst       = vecs[i].rst;
      idata_vld = vecs[i].vld;
      idata     = vecs[i].din;
      odata_rdy = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d_ovld", i), 32'(odata_vld), 32'(vecs[i].exp_ovld));
      check($sformatf("vec%0d_irdy", i), 32'(idata_rdy), 32'(vecs[i].exp_irdy));
      if (vecs[i].chk_dout) begin
        check($sformatf("vec%0d_odata", i), 32'(odata), 32'(vecs[i].exp_dout));
      end
    end

    // Full-rate streaming 0x01..0x10.
    stream(8'h00, 16);

    // Random valid/ready traffic against the queue model, then drain.
    q.delete();
    for (int i = 0; i < 1000; i++) begin
      model_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      if (q.size() != 0) model_step(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(odata_vld), 32'd0);

    // Fill to FULL with 0x55/0x66, then reset mid-cycle.
    idata_vld = 1'b1;
    odata_rdy = 1'b0;
    idata     = 8'h55;
    tick();
    idata     = 8'h66;
    tick();
    check("full_odata", 32'(odata), 32'h55);
    check("full_irdy", 32'(idata_rdy), 32'd0);
    rst = 1'b0;
    #1;
    check("async_rst_ovld", 32'(odata_vld), 32'd0);
    check("async_rst_irdy", 32'(idata_rdy), 32'd0);
    check("async_rst_odata", 32'(odata), 32'h00);
    tick();
    tick();
    rst       = 1'b1;
    idata_vld = 1'b0;
    odata_rdy = 1'b1;
    tick();
    check("release_irdy", 32'(idata_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_ovld", 32'(odata_vld), 32'd0);
      check("post_rst_odata", 32'(odata), 32'h00);
      tick();
    end
`ifdef BHAND_COUNT_EN
    check("count_reset", 32'(xfer_count), 32'd0);
`endif

    // 17 emits after reset; a 4-bit counter wraps to 1.
    stream(8'h70, 17);
`ifdef BHAND_COUNT_EN
    check("count_wrap", 32'(xfer_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
